// File: rtl/wb_axil_bridge_pkg.sv
// rtl/wb_axil_bridge_pkg.sv - shared encodings for the Wishbone to AXI4-Lite bridge
package wb_axil_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WADDR = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam int         CTRL_EN_BIT   = 0;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam int         ERR_CNT_WIDTH = 8;

  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/wb_axil_bridge_if.sv
// rtl/wb_axil_bridge_if.sv - Wishbone pipelined slave and AXI4-Lite master signal bundle
interface wb_axil_bridge_if #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int WB_ADDR_WIDTH = 30
);
  logic                     wb_cyc;
  logic                     wb_stb;
  logic                     wb_we;
  logic [WB_ADDR_WIDTH-1:0] wb_adr;
  logic [DATA_WIDTH-1:0]    wb_dat_w;
  logic [DATA_WIDTH/8-1:0]  wb_sel;
  logic [DATA_WIDTH-1:0]    wb_dat_r;
  logic                     wb_ack;
  logic                     wb_stall;

  logic [ADDR_WIDTH-1:0]    m_axi_awaddr;
  logic [2:0]               m_axi_awprot;
  logic                     m_axi_awvalid;
  logic                     m_axi_awready;
  logic [DATA_WIDTH-1:0]    m_axi_wdata;
  logic [DATA_WIDTH/8-1:0]  m_axi_wstrb;
  logic                     m_axi_wvalid;
  logic                     m_axi_wready;
  logic [1:0]               m_axi_bresp;
  logic                     m_axi_bvalid;
  logic                     m_axi_bready;
  logic [ADDR_WIDTH-1:0]    m_axi_araddr;
  logic [2:0]               m_axi_arprot;
  logic                     m_axi_arvalid;
  logic                     m_axi_arready;
  logic [DATA_WIDTH-1:0]    m_axi_rdata;
  logic [1:0]               m_axi_rresp;
  logic                     m_axi_rvalid;
  logic                     m_axi_rready;

  // Bridge side: Wishbone slave, AXI master.
  modport master (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w, wb_sel,
    output wb_dat_r, wb_ack, wb_stall,
    output m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output m_axi_araddr, m_axi_arprot, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    output m_axi_rready
  );

  // Environment side: Wishbone master, AXI slave.
  modport slave (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w, wb_sel,
    input  wb_dat_r, wb_ack, wb_stall,
    input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_araddr, m_axi_arprot, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    input  m_axi_rready
  );

endinterface

// File: rtl/wb_axil_bridge.sv
// rtl/wb_axil_bridge.sv - single-outstanding Wishbone pipelined to AXI4-Lite master bridge
module wb_axil_bridge
  import wb_axil_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int WB_ADDR_WIDTH = 30
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [DATA_WIDTH-1:0]    ctrl_reg,
  input  logic [ADDR_WIDTH-1:0]    base_reg,
  wb_axil_bridge_if.master         bus,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  state_t                   state_q, state_d;
  logic                     aw_valid_q, aw_valid_d;
  logic                     w_valid_q, w_valid_d;
  logic                     b_ready_q, b_ready_d;
  logic                     ar_valid_q, ar_valid_d;
  logic                     r_ready_q, r_ready_d;
  logic [ADDR_WIDTH-1:0]    aw_addr_q, aw_addr_d;
  logic [ADDR_WIDTH-1:0]    ar_addr_q, ar_addr_d;
  logic [DATA_WIDTH-1:0]    w_data_q, w_data_d;
  logic [STRB_WIDTH-1:0]    w_strb_q, w_strb_d;
  logic [DATA_WIDTH-1:0]    rd_data_q, rd_data_d;
  logic [ERR_CNT_WIDTH-1:0] err_q, err_d;

  logic                     accept;
  logic                     enabled;
  logic [WB_ADDR_WIDTH-1:0] req_word;
  logic [ADDR_WIDTH-1:0]    req_addr;
  logic                     unused_ctrl;

  assign accept      = bus.wb_cyc & bus.wb_stb & (state_q == ST_IDLE);
  assign enabled     = ctrl_reg[CTRL_EN_BIT];
  assign req_word    = bus.wb_adr;
  // Byte address wraps modulo 2^ADDR_WIDTH by construction of the sum width.
  assign req_addr    = base_reg + ADDR_WIDTH'({req_word, 2'b00});
  assign unused_ctrl = ^ctrl_reg;

  always_comb begin
    state_d    = state_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    b_ready_d  = b_ready_q;
    ar_valid_d = ar_valid_q;
    r_ready_d  = r_ready_q;
    aw_addr_d  = aw_addr_q;
    ar_addr_d  = ar_addr_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    rd_data_d  = rd_data_q;
    err_d      = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!enabled) begin
            state_d   = ST_DONE;
            rd_data_d = '0;
            err_d     = sat_inc(err_q);
          end else if (bus.wb_we) begin
            state_d    = ST_WADDR;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            aw_addr_d  = req_addr;
            w_data_d   = bus.wb_dat_w;
            w_strb_d   = bus.wb_sel;
          end else begin
            state_d    = ST_RADDR;
            ar_valid_d = 1'b1;
            ar_addr_d  = req_addr;
          end
        end
      end
      ST_WADDR: begin
        // A low valid in WADDR means that channel's handshake already happened.
        if (aw_valid_q && bus.m_axi_awready) aw_valid_d = 1'b0;
        if (w_valid_q && bus.m_axi_wready)   w_valid_d  = 1'b0;
        if (!aw_valid_d && !w_valid_d) begin
          state_d   = ST_WRESP;
          b_ready_d = 1'b1;
        end
      end
      ST_WRESP: begin
        if (bus.m_axi_bvalid) begin
          state_d   = ST_DONE;
          b_ready_d = 1'b0;
          if (bus.m_axi_bresp != AXI_RESP_OKAY) err_d = sat_inc(err_q);
        end
      end
      ST_RADDR: begin
        if (bus.m_axi_arready) begin
          state_d    = ST_RDATA;
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
        end
      end
      ST_RDATA: begin
        if (bus.m_axi_rvalid) begin
          state_d   = ST_DONE;
          r_ready_d = 1'b0;
          rd_data_d = bus.m_axi_rdata;
          if (bus.m_axi_rresp != AXI_RESP_OKAY) err_d = sat_inc(err_q);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      aw_addr_q  <= '0;
      ar_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      rd_data_q  <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      b_ready_q  <= b_ready_d;
      ar_valid_q <= ar_valid_d;
      r_ready_q  <= r_ready_d;
      aw_addr_q  <= aw_addr_d;
      ar_addr_q  <= ar_addr_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      rd_data_q  <= rd_data_d;
      err_q      <= err_d;
    end
  end

  // Ack is withheld when the master has abandoned the cycle.
  assign bus.wb_ack        = (state_q == ST_DONE) & bus.wb_cyc;
  assign bus.wb_stall      = (state_q != ST_IDLE);
  assign bus.wb_dat_r      = rd_data_q;
  assign bus.m_axi_awaddr  = aw_addr_q;
  assign bus.m_axi_awprot  = 3'b000;
  assign bus.m_axi_awvalid = aw_valid_q;
  assign bus.m_axi_wdata   = w_data_q;
  assign bus.m_axi_wstrb   = w_strb_q;
  assign bus.m_axi_wvalid  = w_valid_q;
  assign bus.m_axi_bready  = b_ready_q;
  assign bus.m_axi_araddr  = ar_addr_q;
  assign bus.m_axi_arprot  = 3'b000;
  assign bus.m_axi_arvalid = ar_valid_q;
  assign bus.m_axi_rready  = r_ready_q;
  assign err_count         = err_q;

endmodule

// File: tb/tb_wb_axil_bridge.sv
// tb/tb_wb_axil_bridge.sv - self-checking bench for wb_axil_bridge
module tb_wb_axil_bridge;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] ctrl_reg;
  logic [31:0] base_reg;
  logic [7:0]  err_count;

  always #5 aclk = ~aclk;

  wb_axil_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WB_ADDR_WIDTH(30)) bus ();

  wb_axil_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WB_ADDR_WIDTH(30)) dut (
    .aclk      (aclk),
    .areset    (areset),
    .ctrl_reg  (ctrl_reg),
    .base_reg  (base_reg),
    .bus       (bus),
    .err_count (err_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // AXI slave configuration, written by the stimulus process only
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = 32'h0;

  // AXI slave: each ready/valid appears after a configurable number of cycles
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  initial begin
    bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0;
    bus.m_axi_bvalid  = 1'b0; bus.m_axi_bresp  = 2'b00;
    bus.m_axi_arready = 1'b0; bus.m_axi_rvalid = 1'b0;
    bus.m_axi_rresp   = 2'b00; bus.m_axi_rdata = 32'h0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    forever begin
      @(posedge aclk); #1;
      bus.m_axi_awready = bus.m_axi_awvalid && (aw_cnt >= aw_dly);
      aw_cnt = bus.m_axi_awvalid ? aw_cnt + 1 : 0;
      bus.m_axi_wready = bus.m_axi_wvalid && (w_cnt >= w_dly);
      w_cnt = bus.m_axi_wvalid ? w_cnt + 1 : 0;
      bus.m_axi_bvalid = bus.m_axi_bready && (b_cnt >= b_dly);
      b_cnt = bus.m_axi_bready ? b_cnt + 1 : 0;
      bus.m_axi_bresp = bus.m_axi_bvalid ? bresp_cfg : 2'b00;
      bus.m_axi_arready = bus.m_axi_arvalid && (ar_cnt >= ar_dly);
      ar_cnt = bus.m_axi_arvalid ? ar_cnt + 1 : 0;
      bus.m_axi_rvalid = bus.m_axi_rready && (r_cnt >= r_dly);
      r_cnt = bus.m_axi_rready ? r_cnt + 1 : 0;
      bus.m_axi_rresp = bus.m_axi_rvalid ? rresp_cfg : 2'b00;
      bus.m_axi_rdata = bus.m_axi_rvalid ? rdata_cfg : 32'hDEAD_BEEF;
    end
  end

  function automatic logic [7:0] bump(input logic [7:0] v);
    if (v == 8'd255) return v;
    return v + 8'd1;
  endfunction

  // Transaction-level reference: one outstanding request, ack the cycle after completion
  bit          pending, ack_due, prev_rst;
  bit          t_we, t_en;
  logic [31:0] t_addr, t_data, t_rdata;
  logic [3:0]  t_sel;
  logic [7:0]  m_err;
  int cyc_n, ack_cnt, aw_hs, w_hs, b_hs, ar_vcnt, v_cnt;
  int aw_hs_cyc, w_hs_cyc, b_hs_cyc, ack_cyc;
  logic [31:0] last_awaddr, last_wdata, last_araddr;
  logic [3:0]  last_wstrb;

  initial begin
    pending = 0; ack_due = 0; prev_rst = 0; t_we = 0; t_en = 0;
    t_addr = '0; t_data = '0; t_rdata = '0; t_sel = '0; m_err = '0;
    cyc_n = 0; ack_cnt = 0; aw_hs = 0; w_hs = 0; b_hs = 0; ar_vcnt = 0; v_cnt = 0;
    aw_hs_cyc = 0; w_hs_cyc = 0; b_hs_cyc = 0; ack_cyc = 0;
    last_awaddr = '0; last_wdata = '0; last_araddr = '0; last_wstrb = '0;
    forever begin
      @(negedge aclk);
      cyc_n++;
      if (prev_rst) begin
        chk("rst_ctl", {25'd0, bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready,
                        bus.m_axi_arvalid, bus.m_axi_rready, bus.wb_ack, bus.wb_stall}, 32'd0);
        chk("rst_awaddr", bus.m_axi_awaddr, 32'd0);
        chk("rst_araddr", bus.m_axi_araddr, 32'd0);
        chk("rst_wdata", bus.m_axi_wdata, 32'd0);
        chk("rst_wstrb", 32'(bus.m_axi_wstrb), 32'd0);
        chk("rst_dat_r", bus.wb_dat_r, 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
      end
      chk("stall", 32'(bus.wb_stall), 32'(pending));
      chk("ack", 32'(bus.wb_ack), 32'(ack_due & bus.wb_cyc));
      chk("err_count", 32'(err_count), 32'(m_err));
      chk("prot", {26'd0, bus.m_axi_awprot, bus.m_axi_arprot}, 32'd0);
      if (bus.wb_ack && (!t_we || !t_en))
        chk("dat_r", bus.wb_dat_r, t_en ? t_rdata : 32'd0);
      if (bus.m_axi_awvalid) begin
        chk("aw_ctx", 32'(pending & t_we & t_en & !ack_due), 32'd1);
        chk("awaddr", bus.m_axi_awaddr, t_addr);
      end
      if (bus.m_axi_wvalid) begin
        chk("w_ctx", 32'(pending & t_we & t_en & !ack_due), 32'd1);
        chk("wdata", bus.m_axi_wdata, t_data);
        chk("wstrb", 32'(bus.m_axi_wstrb), 32'(t_sel));
      end
      if (bus.m_axi_bready) chk("b_ctx", 32'(pending & t_we & t_en & !ack_due), 32'd1);
      if (bus.m_axi_arvalid) begin
        chk("ar_ctx", 32'(pending & !t_we & t_en & !ack_due), 32'd1);
        chk("araddr", bus.m_axi_araddr, t_addr);
      end
      if (bus.m_axi_rready) chk("r_ctx", 32'(pending & !t_we & t_en & !ack_due), 32'd1);

      if (bus.m_axi_awvalid || bus.m_axi_wvalid || bus.m_axi_arvalid) v_cnt++;
      if (bus.m_axi_arvalid) begin ar_vcnt++; last_araddr = bus.m_axi_araddr; end
      if (bus.m_axi_awvalid && bus.m_axi_awready) begin aw_hs++; aw_hs_cyc = cyc_n; last_awaddr = bus.m_axi_awaddr; end
      if (bus.m_axi_wvalid && bus.m_axi_wready) begin
        w_hs++; w_hs_cyc = cyc_n; last_wdata = bus.m_axi_wdata; last_wstrb = bus.m_axi_wstrb;
      end
      if (bus.m_axi_bvalid && bus.m_axi_bready) begin b_hs++; b_hs_cyc = cyc_n; end
      if (bus.wb_ack) begin ack_cnt++; ack_cyc = cyc_n; end

      prev_rst = areset;
      if (areset) begin
        pending = 0; ack_due = 0; m_err = '0;
      end else if (ack_due) begin
        ack_due = 0; pending = 0;
      end else if (!pending) begin
        if (bus.wb_cyc && bus.wb_stb) begin
          pending = 1; t_we = bus.wb_we; t_en = ctrl_reg[0];
          t_addr = base_reg + {bus.wb_adr, 2'b00};
          t_data = bus.wb_dat_w; t_sel = bus.wb_sel;
          if (!t_en) begin ack_due = 1; m_err = bump(m_err); end
        end
      end else begin
        if (t_we && bus.m_axi_bvalid && bus.m_axi_bready) begin
          ack_due = 1;
          if (bus.m_axi_bresp != 2'b00) m_err = bump(m_err);
        end
        if (!t_we && bus.m_axi_rvalid && bus.m_axi_rready) begin
          ack_due = 1; t_rdata = bus.m_axi_rdata;
          if (bus.m_axi_rresp != 2'b00) m_err = bump(m_err);
        end
      end
    end
  end

  task automatic wb_xfer(input bit we, input logic [29:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input bit chg,
                         output logic [31:0] rd, output bit ok);
    int n;
    logic [31:0] sb, sc;
    sb = base_reg; sc = ctrl_reg;
    @(posedge aclk); #1;
    bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = we;
    bus.wb_adr = adr; bus.wb_dat_w = dat; bus.wb_sel = sel;
    n = 0;
    while (bus.wb_stall && n < 50) begin @(posedge aclk); #1; n++; end
    @(posedge aclk); #1;
    bus.wb_stb = 1'b0;
    if (chg) begin base_reg = ~base_reg; ctrl_reg = ~ctrl_reg; end
    n = 0;
    while (!bus.wb_ack && n < 100) begin @(posedge aclk); #1; n++; end
    ok = bus.wb_ack; rd = bus.wb_dat_r;
    @(posedge aclk); #1;
    bus.wb_cyc = 1'b0;
    base_reg = sb; ctrl_reg = sc;
    chk("wb_ack_seen", 32'(ok), 32'd1);
  endtask

  task automatic pulse_reset();
    @(posedge aclk); #1; areset = 1'b1;
    @(posedge aclk); #1; areset = 1'b0;
  endtask

  logic [31:0] rd;
  bit          ok;
  int          a0, b0, v0, r0, n;
  int          aw_tab[4] = '{2, 0, 0, 3};
  int          w_tab[4]  = '{0, 2, 0, 1};

  initial begin
    bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0;
    bus.wb_adr = '0; bus.wb_dat_w = '0; bus.wb_sel = '0;
    ctrl_reg = 32'h1; base_reg = 32'h8000_0000;
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    chk("init_stall", 32'(bus.wb_stall), 32'd0);
    chk("init_err", 32'(err_count), 32'd0);
    chk("init_awvalid", 32'(bus.m_axi_awvalid), 32'd0);

    // basic write
    a0 = ack_cnt; b0 = b_hs;
    wb_xfer(1'b1, 30'h10, 32'hCAFE_F00D, 4'hF, 1'b0, rd, ok);
    chk("w1_awaddr", last_awaddr, 32'h8000_0040);
    chk("w1_wdata", last_wdata, 32'hCAFE_F00D);
    chk("w1_wstrb", 32'(last_wstrb), 32'hF);
    chk("w1_bcount", 32'(b_hs - b0), 32'd1);
    chk("w1_acks", 32'(ack_cnt - a0), 32'd1);
    chk("w1_ack_lat", 32'(ack_cyc - b_hs_cyc), 32'd1);

    // read with slow arready
    ar_dly = 3; rdata_cfg = 32'h1234_5678; r0 = ar_vcnt;
    wb_xfer(1'b0, 30'h3, 32'h0, 4'h0, 1'b0, rd, ok);
    chk("r1_data", rd, 32'h1234_5678);
    chk("r1_araddr", last_araddr, 32'h8000_000C);
    chk("r1_ar_cycles", 32'(ar_vcnt - r0), 32'd4);
    ar_dly = 0;

    // independent AW / W handshake ordering
    for (int i = 0; i < 4; i++) begin
      aw_dly = aw_tab[i]; w_dly = w_tab[i];
      a0 = ack_cnt; b0 = b_hs;
      wb_xfer(1'b1, 30'(i + 1), 32'hA000_0000 + 32'(i), 4'(i + 3), 1'b0, rd, ok);
      chk("ord_skew", 32'(aw_hs_cyc - w_hs_cyc), 32'(aw_tab[i] - w_tab[i]));
      chk("ord_bcount", 32'(b_hs - b0), 32'd1);
      chk("ord_acks", 32'(ack_cnt - a0), 32'd1);
    end
    aw_dly = 0; w_dly = 0;

    // address wrap and mid-flight register changes
    base_reg = 32'hFFFF_FFF0;
    wb_xfer(1'b1, 30'h8, 32'h5555_AAAA, 4'h3, 1'b0, rd, ok);
    chk("wrap_awaddr", last_awaddr, 32'h0000_0010);
    rdata_cfg = 32'hA5A5_0001;
    wb_xfer(1'b0, 30'h1, 32'h0, 4'hF, 1'b1, rd, ok);
    chk("chg_araddr", last_araddr, 32'hFFFF_FFF4);
    chk("chg_data", rd, 32'hA5A5_0001);
    base_reg = 32'h8000_0000;

    // master abandons the cycle: transaction completes, no ack
    a0 = ack_cnt; b0 = b_hs;
    @(posedge aclk); #1;
    bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = 1'b1; bus.wb_adr = 30'h5;
    @(posedge aclk); #1;
    bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0;
    repeat (10) @(posedge aclk);
    #1;
    chk("abandon_acks", 32'(ack_cnt - a0), 32'd0);
    chk("abandon_b", 32'(b_hs - b0), 32'd1);

    // disabled bridge, then error counting and saturation
    pulse_reset();
    ctrl_reg = 32'h0; v0 = v_cnt; rdata_cfg = 32'h7777_7777;
    wb_xfer(1'b0, 30'h7, 32'h0, 4'hF, 1'b0, rd, ok);
    chk("dis_data", rd, 32'h0);
    chk("dis_err", 32'(err_count), 32'd1);
    chk("dis_no_valid", 32'(v_cnt - v0), 32'd0);
    ctrl_reg = 32'h1; bresp_cfg = 2'b10;
    for (int i = 0; i < 256; i++) begin
      wb_xfer(1'b1, 30'(i), 32'(i), 4'hF, 1'b0, rd, ok);
      if (i == 99) chk("err_101", 32'(err_count), 32'd101);
    end
    chk("err_sat", 32'(err_count), 32'd255);
    bresp_cfg = 2'b00; rresp_cfg = 2'b10; rdata_cfg = 32'h0BAD_F00D;
    wb_xfer(1'b0, 30'h2, 32'h0, 4'h0, 1'b0, rd, ok);
    chk("slverr_data", rd, 32'h0BAD_F00D);
    chk("slverr_sat", 32'(err_count), 32'd255);
    rresp_cfg = 2'b00;

    // reset while waiting for B, then a clean transaction
    b_dly = 20;
    @(posedge aclk); #1;
    bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = 1'b1;
    bus.wb_adr = 30'h2; bus.wb_dat_w = 32'h1111_1111; bus.wb_sel = 4'hF;
    @(posedge aclk); #1;
    bus.wb_stb = 1'b0;
    n = 0;
    while (!bus.m_axi_bready && n < 20) begin @(posedge aclk); #1; n++; end
    chk("wresp_reached", 32'(bus.m_axi_bready), 32'd1);
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0; bus.wb_cyc = 1'b0;
    chk("rst_bready", 32'(bus.m_axi_bready), 32'd0);
    chk("rst_stall_now", 32'(bus.wb_stall), 32'd0);
    chk("rst_err_now", 32'(err_count), 32'd0);
    b_dly = 0; b0 = b_hs;
    wb_xfer(1'b1, 30'h4, 32'h2222_2222, 4'h5, 1'b0, rd, ok);
    chk("post_rst_awaddr", last_awaddr, 32'h8000_0010);
    chk("post_rst_wdata", last_wdata, 32'h2222_2222);
    chk("post_rst_b", 32'(b_hs - b0), 32'd1);

    repeat (3) @(posedge aclk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
